instr_loader: RTL and testbench

- Program loader upstream of the multi-cycle RISC-V core's instruction/data memory.
- Receives a byte stream (UART RX or bench driver), assembles 32-bit little-endian words and writes them to consecutive word addresses.
- Holds the core in reset while loading and releases it when the image is complete.
- Replaces direct memory pokes for bring-up on FPGA.

---
 rtl/instr_loader.sv | 176 +++++++++++++++++
 tb/tb_instr_loader.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
// Byte-stream program loader: assembles LE words, writes memory, gates core reset.
// Optional trailing XOR checksum byte when INSTR_LOADER_CKSUM_EN is defined.
module instr_loader #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wd,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
`ifdef INSTR_LOADER_CKSUM_EN
    , S_CKSUM
`endif
  } state_t;

  localparam logic [ADDR_W-1:0] L_BASE = ADDR_W'(BASE_ADDR);
  localparam logic [16:0]       L_MAX  = 17'(64'd1 << ADDR_W);

  state_t            r_state;
  logic              r_rx_ready;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wd;
  logic              r_cpu_rst;
  logic              r_done;
  logic              r_err;
  logic [15:0]       r_len;
  logic [1:0]        r_bidx;
  logic [16:0]       r_wcnt;
  logic [31:0]       r_asm;
  logic [7:0]        r_xor;

  logic              w_fire;
  logic [15:0]       w_len;
  logic              w_len_bad;
  logic [16:0]       w_wcnt_inc;
  logic              w_last;
  logic [ADDR_W-1:0] w_addr;

  assign w_fire     = rx_valid & r_rx_ready;
  assign w_len      = {rx_data, r_len[7:0]};
  assign w_len_bad  = (w_len == 16'd0) || ({1'b0, w_len} > L_MAX);
  assign w_wcnt_inc = r_wcnt + 17'd1;
  assign w_last     = (w_wcnt_inc == {1'b0, r_len});
  // Truncation to ADDR_W makes the image wrap around the address space.
  assign w_addr     = L_BASE + r_wcnt[ADDR_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_rx_ready <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= L_BASE;
      r_wd       <= 32'd0;
      r_cpu_rst  <= 1'b1;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_len      <= 16'd0;
      r_bidx     <= 2'd0;
      r_wcnt     <= 17'd0;
      r_asm      <= 32'd0;
      r_xor      <= 8'd0;
    end else begin
      r_we <= 1'b0;
      unique case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (load) begin
            r_state    <= S_LEN0;
            r_rx_ready <= 1'b1;
            r_cpu_rst  <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
          end
        end
        S_LEN0: begin
          if (w_fire) begin
            r_len[7:0] <= rx_data;
            r_state    <= S_LEN1;
          end
        end
        S_LEN1: begin
          if (w_fire) begin
            r_len[15:8] <= rx_data;
            r_bidx      <= 2'd0;
            r_wcnt      <= 17'd0;
            r_xor       <= 8'd0;
            if (w_len_bad) begin
              r_state    <= S_ERR;
              r_rx_ready <= 1'b0;
              r_err      <= 1'b1;
            end else begin
              r_state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_fire) begin
            r_bidx <= r_bidx + 2'd1;
            r_xor  <= r_xor ^ rx_data;
            r_asm[{r_bidx, 3'b000} +: 8] <= rx_data;
            if (r_bidx == 2'd3) begin
              r_wd       <= {rx_data, r_asm[23:0]};
              r_addr     <= w_addr;
              r_we       <= 1'b1;
              r_rx_ready <= 1'b0;
              r_state    <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          r_wcnt <= w_wcnt_inc;
          if (w_last) begin
`ifdef INSTR_LOADER_CKSUM_EN
            r_state    <= S_CKSUM;
            r_rx_ready <= 1'b1;
`else
            r_state   <= S_DONE;
            r_cpu_rst <= 1'b0;
            r_done    <= 1'b1;
`endif
          end else begin
            r_state    <= S_DATA;
            r_rx_ready <= 1'b1;
          end
        end
`ifdef INSTR_LOADER_CKSUM_EN
        S_CKSUM: begin
          if (w_fire) begin
            r_rx_ready <= 1'b0;
            if (rx_data == r_xor) begin
              r_state   <= S_DONE;
              r_cpu_rst <= 1'b0;
              r_done    <= 1'b1;
            end else begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end
          end
        end
`endif
        default: begin
          r_state    <= S_IDLE;
          r_rx_ready <= 1'b0;
          r_cpu_rst  <= 1'b1;
        end
      endcase
    end
  end

  assign rx_ready = r_rx_ready;
  assign mem_we   = r_we;
  assign mem_addr = r_addr;
  assign mem_wd   = r_wd;
  assign cpu_rst  = r_cpu_rst;
  assign done     = r_done;
  assign err      = r_err;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: default instance and a 4-word instance at base 3.
// Honours INSTR_LOADER_CKSUM_EN by appending the checksum byte.
module tb_instr_loader;

  logic clk = 1'b0;
  logic rst;
  logic load_a, load_b;
  logic rx_valid;
  logic [7:0] rx_data;

  logic rdy_a, we_a, cpu_rst_a, done_a, err_a;
  logic [7:0] addr_a;
  logic [31:0] wd_a;
  logic rdy_b, we_b, cpu_rst_b, done_b, err_b;
  logic [1:0] addr_b;
  logic [31:0] wd_b;

  int n_chk = 0;
  int n_fail = 0;
  int bad_rdy = 0;
  int bad_cpu = 0;
  bit in_load = 1'b0;

  logic [31:0] qa_addr[$], qa_data[$];
  logic [31:0] qb_addr[$], qb_data[$];
  logic [7:0] img[$];

  always #5 clk = ~clk;

  instr_loader u_dut_a (
    .clk(clk), .rst(rst), .load(load_a),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rdy_a), .mem_we(we_a), .mem_addr(addr_a),
    .mem_wd(wd_a), .cpu_rst(cpu_rst_a), .done(done_a), .err(err_a)
  );

  instr_loader #(.ADDR_W(2), .BASE_ADDR(3)) u_dut_b (
    .clk(clk), .rst(rst), .load(load_b),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rdy_b), .mem_we(we_b), .mem_addr(addr_b),
    .mem_wd(wd_b), .cpu_rst(cpu_rst_b), .done(done_b), .err(err_b)
  );

  always @(negedge clk) begin
    if (we_a) begin
      qa_addr.push_back(32'(addr_a));
      qa_data.push_back(wd_a);
      if (rdy_a) bad_rdy++;
    end
    if (we_b) begin
      qb_addr.push_back(32'(addr_b));
      qb_data.push_back(wd_b);
      if (rdy_b) bad_rdy++;
    end
    if (in_load && !cpu_rst_a) bad_cpu++;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xsum();
    logic [7:0] x = 8'h00;
    for (int i = 2; i < img.size(); i++) x ^= img[i];
    return x;
  endfunction

  task automatic set_basic(input bit with_ck);
    img = '{8'h03, 8'h00,
            8'h13, 8'h70, 8'hf2, 8'h0f,
            8'h13, 8'hf2, 8'hf2, 8'h0f,
            8'h13, 8'h72, 8'hf3, 8'h0f};
`ifdef INSTR_LOADER_CKSUM_EN
    if (with_ck) img.push_back(xsum());
`endif
  endtask

  task automatic pulse(input bit sel);
    @(negedge clk);
    if (sel) load_b = 1'b1;
    else load_a = 1'b1;
    @(negedge clk);
    load_a = 1'b0;
    load_b = 1'b0;
  endtask

  task automatic send_img(input bit sel, input bit gap);
    foreach (img[i]) begin
      int t;
      t = 0;
      if (gap) begin
        @(negedge clk);
        rx_valid = 1'b0;
      end
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data = img[i];
      while (!(sel ? rdy_b : rdy_a) && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (t >= 50) begin
        chk("rx_timeout", 32'(sel ? rdy_b : rdy_a), 32'd1);
        return;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_end(input bit sel);
    int t;
    t = 0;
    while (t < 40 && !(sel ? (done_b | err_b) : (done_a | err_a))) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic chk_basic(input string tag);
    chk({tag, "_nwr"}, 32'(qa_addr.size()), 32'd3);
    chk({tag, "_a0"}, qa_addr[0], 32'd0);
    chk({tag, "_a1"}, qa_addr[1], 32'd1);
    chk({tag, "_a2"}, qa_addr[2], 32'd2);
    chk({tag, "_d0"}, qa_data[0], 32'h0ff27013);
    chk({tag, "_d1"}, qa_data[1], 32'h0ff2f213);
    chk({tag, "_d2"}, qa_data[2], 32'h0ff37213);
  endtask

  task automatic run_basic_a(input string tag, input bit gap);
    qa_addr.delete();
    qa_data.delete();
    set_basic(1'b1);
    pulse(1'b0);
    chk({tag, "_cpurst_on_load"}, 32'(cpu_rst_a), 32'd1);
    chk({tag, "_done_clr"}, 32'(done_a), 32'd0);
    in_load = 1'b1;
    send_img(1'b0, gap);
    in_load = 1'b0;
    wait_end(1'b0);
    chk_basic(tag);
    chk({tag, "_done"}, 32'(done_a), 32'd1);
    chk({tag, "_cpurst"}, 32'(cpu_rst_a), 32'd0);
    chk({tag, "_err"}, 32'(err_a), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    load_a = 1'b0;
    load_b = 1'b0;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_rdy", 32'(rdy_a), 32'd0);
    chk("rst_we", 32'(we_a), 32'd0);
    chk("rst_addr", 32'(addr_a), 32'd0);
    chk("rst_wd", wd_a, 32'd0);
    chk("rst_cpurst", 32'(cpu_rst_a), 32'd1);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_err", 32'(err_a), 32'd0);
    chk("rst_addr_b", 32'(addr_b), 32'd3);
    rst = 1'b1;
    @(negedge clk);

    run_basic_a("basic", 1'b0);
    run_basic_a("gap", 1'b1);
    chk("no_rdy_in_write", 32'(bad_rdy), 32'd0);
    chk("cpurst_held", 32'(bad_cpu), 32'd0);

    qa_addr.delete();
    qa_data.delete();
    img = '{8'h00, 8'h00};
    pulse(1'b0);
    send_img(1'b0, 1'b0);
    wait_end(1'b0);
    chk("len0_err", 32'(err_a), 32'd1);
    chk("len0_nwr", 32'(qa_addr.size()), 32'd0);
    chk("len0_cpurst", 32'(cpu_rst_a), 32'd1);
    chk("len0_done", 32'(done_a), 32'd0);
    run_basic_a("after_err", 1'b0);

    qa_addr.delete();
    qa_data.delete();
    set_basic(1'b0);
    img = img[0:7];
    pulse(1'b0);
    send_img(1'b0, 1'b0);
    @(negedge clk);
    rx_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("mid_nwr", 32'(qa_addr.size()), 32'd1);
    chk("mid_rdy", 32'(rdy_a), 32'd0);
    chk("mid_we", 32'(we_a), 32'd0);
    chk("mid_addr", 32'(addr_a), 32'd0);
    chk("mid_wd", wd_a, 32'd0);
    chk("mid_cpurst", 32'(cpu_rst_a), 32'd1);
    chk("mid_done", 32'(done_a), 32'd0);
    chk("mid_err", 32'(err_a), 32'd0);
    run_basic_a("post_rst", 1'b0);

`ifdef INSTR_LOADER_CKSUM_EN
    qa_addr.delete();
    qa_data.delete();
    set_basic(1'b0);
    img.push_back(8'h00);
    pulse(1'b0);
    send_img(1'b0, 1'b0);
    wait_end(1'b0);
    chk_basic("badck");
    chk("badck_err", 32'(err_a), 32'd1);
    chk("badck_done", 32'(done_a), 32'd0);
    chk("badck_cpurst", 32'(cpu_rst_a), 32'd1);
`endif

    img = '{8'h05, 8'h00};
    pulse(1'b1);
    send_img(1'b1, 1'b0);
    wait_end(1'b1);
    chk("b_len5_err", 32'(err_b), 32'd1);
    chk("b_len5_nwr", 32'(qb_addr.size()), 32'd0);
    chk("b_len5_cpurst", 32'(cpu_rst_b), 32'd1);

    img = '{8'h04, 8'h00,
            8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
            8'h09, 8'h0a, 8'h0b, 8'h0c, 8'h0d, 8'h0e, 8'h0f, 8'h10};
`ifdef INSTR_LOADER_CKSUM_EN
    img.push_back(xsum());
`endif
    pulse(1'b1);
    chk("b_err_clr", 32'(err_b), 32'd0);
    send_img(1'b1, 1'b1);
    wait_end(1'b1);
    chk("wrap_nwr", 32'(qb_addr.size()), 32'd4);
    chk("wrap_a0", qb_addr[0], 32'd3);
    chk("wrap_a1", qb_addr[1], 32'd0);
    chk("wrap_a2", qb_addr[2], 32'd1);
    chk("wrap_a3", qb_addr[3], 32'd2);
    chk("wrap_d0", qb_data[0], 32'h04030201);
    chk("wrap_d3", qb_data[3], 32'h100f0e0d);
    chk("wrap_done", 32'(done_b), 32'd1);
    chk("wrap_cpurst", 32'(cpu_rst_b), 32'd0);
    chk("final_no_rdy_in_write", 32'(bad_rdy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
